// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with valid/ready on both sides.
// A word captured on the load port is streamed one bit per accepted serial
// beat. A new word may be loaded on the same edge as the last bit so that
// consecutive words stream with no bubble.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no word held; ser_valid=0, load_ready=1
// SHIFT | word held; ser_valid=1, ser_out presents the current bit
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy,
    output logic [CW-1:0]    bits_left
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bits_left_q, bits_left_d;

    logic load_acc;
    logic bit_acc;

    // Handshake outputs are combinational from the registered state.
    always_comb begin
        ser_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        bits_left  = bits_left_q;
        ser_last   = ser_valid && (bits_left_q == CW'(1));
        load_ready = (state_q == IDLE) || (ser_last && ser_ready);
        ser_out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        load_acc   = load_valid && load_ready;
        bit_acc    = ser_valid && ser_ready;
    end

    // Next state: a load always wins over the shift of the final bit, which
    // is what makes back-to-back words seamless.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        if (load_acc) begin
            shreg_d     = load_data;
            bits_left_d = CW'(WIDTH);
            state_d     = SHIFT;
        end else if (bit_acc) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (bits_left_q != '0) begin
                bits_left_d = bits_left_q - CW'(1);
            end
            if (bits_left_q <= CW'(1)) begin
                state_d = IDLE;
            end
        end
    end

    // State registers with synchronous reset; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench: an MSB-first and an LSB-first instance share the same
// stimulus; expected bit streams are hand-derived from the loaded words.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic       m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy;
    logic [3:0] m_bits_left;
    logic       l_load_ready, l_ser_valid, l_ser_out, l_ser_last, l_busy;
    logic [3:0] l_bits_left;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(m_load_ready), .load_data(load_data),
        .ser_valid(m_ser_valid), .ser_ready(ser_ready), .ser_out(m_ser_out),
        .ser_last(m_ser_last), .busy(m_busy), .bits_left(m_bits_left)
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(l_load_ready), .load_data(load_data),
        .ser_valid(l_ser_valid), .ser_ready(ser_ready), .ser_out(l_ser_out),
        .ser_last(l_ser_last), .busy(l_busy), .bits_left(l_bits_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " ser_valid"},  m_ser_valid, 0);
        chk({tag, " busy"},       m_busy, 0);
        chk({tag, " bits_left"},  m_bits_left, 0);
        chk({tag, " load_ready"}, m_load_ready, 1);
        chk({tag, " ser_out"},    m_ser_out, 0);
        chk({tag, " ser_last"},   m_ser_last, 0);
        chk({tag, " lsb ser_valid"}, l_ser_valid, 0);
    endtask

    logic [7:0]  w;
    logic [15:0] w2;
    logic [3:0]  pat;
    int          got;
    int          cyc;

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; ser_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check_idle("reset");

        // Test 1/2: A5 with ser_ready held, both bit orders.
        w = 8'hA5;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t1 bit%0d", i), m_ser_out, w[7-i]);
            chk($sformatf("t1 valid%0d", i), m_ser_valid, 1);
            chk($sformatf("t1 last%0d", i), m_ser_last, (i == 7));
            chk($sformatf("t1 left%0d", i), m_bits_left, 8 - i);
            chk($sformatf("t2 bit%0d", i), l_ser_out, w[i]);
            chk($sformatf("t2 left%0d", i), l_bits_left, 8 - i);
            chk($sformatf("t2 last%0d", i), l_ser_last, (i == 7));
            tick();
        end
        settle();
        check_idle("t1 end");
        chk("t2 end busy", l_busy, 0);
        chk("t2 end load_ready", l_load_ready, 1);

        // Test 3: backpressure with ser_ready pattern 1,0,0,1.
        w = 8'h3C;
        pat = 4'b1001;
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            ser_ready = pat[cyc % 4];
            settle();
            chk($sformatf("t3 bit%0d c%0d", got, cyc), m_ser_out, w[7-got]);
            chk($sformatf("t3 left c%0d", cyc), m_bits_left, 8 - got);
            chk($sformatf("t3 valid c%0d", cyc), m_ser_valid, 1);
            chk($sformatf("t3 last c%0d", cyc), m_ser_last, (got == 7));
            chk($sformatf("t3 lsb bit c%0d", cyc), l_ser_out, w[got]);
            if (ser_ready) got++;
            tick();
            cyc++;
        end
        chk("t3 all bits in budget", got, 8);
        ser_ready = 1'b1;
        settle();
        check_idle("t3 end");

        // Test 4: back-to-back F0 then 0F, no bubble.
        w2 = 16'hF00F;
        load_valid = 1'b1; load_data = 8'hF0;
        tick();
        load_data = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("t4 valid%0d", i), m_ser_valid, 1);
            chk($sformatf("t4 bit%0d", i), m_ser_out, w2[15-i]);
            if (i < 8) chk($sformatf("t4 ready%0d", i), m_load_ready, (i == 7));
            tick();
            if (i == 7) load_valid = 1'b0;
        end
        settle();
        check_idle("t4 end");

        // Test 5: load of 00 offered mid-word of FF is held off until last bit.
        load_valid = 1'b1; load_data = 8'hFF;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_valid = 1'b1; load_data = 8'h00;
            end
            settle();
            chk($sformatf("t5 bit%0d", i), m_ser_out, 1);
            chk($sformatf("t5 left%0d", i), m_bits_left, 8 - i);
            if (i >= 3) chk($sformatf("t5 ready%0d", i), m_load_ready, (i == 7));
            tick();
        end
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t5 zero valid%0d", i), m_ser_valid, 1);
            chk($sformatf("t5 zero bit%0d", i), m_ser_out, 0);
            tick();
        end
        settle();
        check_idle("t5 end");

        // Test 6: reset after 3 bits of A5, then a clean 81.
        w = 8'hA5;
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick();
        settle();
        chk("t6 pre-reset left", m_bits_left, 5);
        load_valid = 1'b1; load_data = 8'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0; load_valid = 1'b0;
        settle();
        check_idle("t6 after reset");
        chk("t6 lsb bits_left", l_bits_left, 0);
        w = 8'h81;
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t6 bit%0d", i), m_ser_out, w[7-i]);
            chk($sformatf("t6 lsb bit%0d", i), l_ser_out, w[i]);
            chk($sformatf("t6 left%0d", i), m_bits_left, 8 - i);
            tick();
        end
        settle();
        check_idle("t6 end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parametrised parallel-in/serial-out shift register. It is the successor to the team's fixed 4-bit parallel-load register. It captures a WIDTH-bit word through a valid/ready load port and streams the word out one bit per accepted serial handshake. Bit order is selectable. Back-to-back words stream with no idle cycle. It sits between parallel datapath logic and any bit-serial consumer (serial link or test pin).

Parameters:
WIDTH, 8, word width in bits; legal range 2 to 64
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clk  input  1  the block's single clock; all logic updates on its rising edge
rst  input  1  reset; synchronous and active-high
load_valid  input  1  load_data is offered
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  parallel word to serialise
ser_valid  output  1  ser_out holds a valid bit
ser_ready  input  1  consumer takes ser_out this cycle
ser_out  output  1  current serial bit
ser_last  output  1  current bit is the final bit of the word
busy  output  1  a word is loaded and not fully transmitted
bits_left  output  $clog2(WIDTH+1)  bits not yet accepted, including the current bit

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at a rising edge):
  - Shift register cleared to 0; bits_left=0.
  - State=IDLE; ser_valid=0, ser_out=0, ser_last=0, busy=0.
  - load_ready=1 from the first cycle after reset.
  - A reset mid-word discards the remaining bits; no partial word is emitted afterwards.
- States:
  - IDLE: no word held. ser_valid=0, busy=0, load_ready=1.
  - SHIFT: word held. ser_valid=1, busy=1.
- Load handshake: a load is accepted when load_valid & load_ready at a rising edge.
  - The word is captured into the register; bits_left=WIDTH; state goes to SHIFT.
  - The first bit is presented on ser_out in the cycle after acceptance (1-cycle latency).
- Serial handshake: a bit is accepted when ser_valid & ser_ready at a rising edge.
  - MSB_FIRST=1: shift left, fill with 0. MSB_FIRST=0: shift right, fill with 0.
  - bits_left decrements by 1.
- ser_out selection: MSB_FIRST=1 drives register bit WIDTH-1; MSB_FIRST=0 drives register bit 0. ser_out is combinational from the register.
- ser_last = (bits_left==1) & ser_valid.
- load_ready = IDLE | (ser_last & ser_ready). When the final bit and a new load are accepted on the same edge:
  - The new word is captured, bits_left=WIDTH, state stays SHIFT.
  - Result is seamless streaming with zero bubble.
- End of word: the final bit is accepted with no load on the same edge -> state=IDLE next cycle, ser_valid=0, bits_left=0.
- Backpressure:
  - ser_ready=0 holds the register, ser_out, bits_left and ser_last stable indefinitely.
  - ser_valid never drops while a word is in progress.
- Load during SHIFT, not on the final bit: load_ready=0, so load_data is ignored and the current word is unaffected.
- ser_ready while IDLE: ignored.
- Counter width is $clog2(WIDTH+1) and the counter never underflows. Decrement occurs only on an accepted bit while bits_left>0.
- Simultaneous rst and any handshake: rst wins.

Test Plan:
1. Reset, then WIDTH=8, MSB_FIRST=1, load 8'hA5, ser_ready=1 held -> ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load. ser_last high only on the 8th bit; busy falls and load_ready rises the cycle after the 8th bit.
2. MSB_FIRST=0, load 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 read LSB first (bits 0..7 = 1,0,1,0,0,1,0,1). bits_left counts 8 down to 1.
3. Backpressure: load 8'h3C, ser_ready toggles 1,0,0,1,... -> each bit held while ser_ready=0. All 8 bits 0,0,1,1,1,1,0,0 appear in order with none dropped or duplicated; bits_left changes only on accepted beats.
4. Back-to-back: load 8'hF0; hold load_valid=1 with 8'h0F queued and ser_ready=1 -> 16 contiguous valid bits 11110000 00001111 with ser_valid never low. Second load accepted on the same edge as the first word's last bit.
5. Load ignored mid-word: during bit 3 of 8'hFF, assert load_valid with 8'h00 -> load_ready=0, the output continues as all 1s, and the 8'h00 is accepted only at the last-bit edge.
6. Reset mid-word: rst=1 after 3 bits of 8'hA5 -> next cycle ser_valid=0, busy=0, bits_left=0, load_ready=1. A new load of 8'h81 then emits 1,0,0,0,0,0,0,1 cleanly.
